// File: rtl/hdmi_tmds_pkg.sv
// Shared TMDS symbol constants, period encodings and lookup helpers
// for the HDMI multi-channel encoder slice.
package hdmi_tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL  = 3'd0,
    MODE_VIDEO = 3'd1,
    MODE_VGB   = 3'd2,
    MODE_TERC4 = 3'd3,
    MODE_DGB   = 3'd4
  } mode_e;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic [9:0] GB_VIDEO_EVEN = 10'b1011001100;
  localparam logic [9:0] GB_VIDEO_ODD  = 10'b0100110011;

  function automatic logic [9:0] ctrl_code(
    input logic [1:0] c
  );
    logic [9:0] s;
    case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc4(
    input logic [3:0] n
  );
    logic [9:0] s;
    case (n)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  // Reserved encodings 5-7 collapse to CTRL at the pipeline input.
  function automatic mode_e norm_mode(
    input logic [2:0] m
  );
    mode_e r;
    case (m)
      3'd1:    r = MODE_VIDEO;
      3'd2:    r = MODE_VGB;
      3'd3:    r = MODE_TERC4;
      3'd4:    r = MODE_DGB;
      default: r = MODE_CTRL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS lane: stage 1 registers fields and builds q_m, stage 2
// picks the symbol and tracks running disparity (cnt).
// Ports: clk, reset, mode (stage-1 mode), data/ctrl/terc in, tmds out.
module tmds_channel_enc
  import hdmi_tmds_pkg::*;
#(
  parameter int         CH_INDEX = 0,
  parameter logic [9:0] GB_EVEN  = GB_VIDEO_EVEN,
  parameter logic [9:0] GB_ODD   = GB_VIDEO_ODD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic [7:0] data,
  input  logic [1:0] ctrl,
  input  logic [3:0] terc,
  output logic [9:0] tmds
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] qm_c;
  logic [3:0] n1q_c;

  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++)
      n1d = n1d + {3'b0, data[i]};
    use_xnor = (n1d > 4'd4) ||
               ((n1d == 4'd4) && !data[0]);
    qm_c = '0;
    qm_c[0] = data[0];
    for (int i = 1; i < 8; i++)
      qm_c[i] = qm_c[i-1] ^ data[i] ^ use_xnor;
    qm_c[8] = ~use_xnor;
    n1q_c = '0;
    for (int i = 0; i < 8; i++)
      n1q_c = n1q_c + {3'b0, qm_c[i]};
  end

  logic [8:0] qm;
  logic [3:0] n1q;
  logic [1:0] ctrl_r;
  logic [3:0] terc_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      qm     <= '0;
      n1q    <= '0;
      ctrl_r <= '0;
      terc_r <= '0;
    end else begin
      qm     <= qm_c;
      n1q    <= n1q_c;
      ctrl_r <= ctrl;
      terc_r <= terc;
    end
  end

  logic signed [5:0] cnt;
  logic signed [5:0] cnt_v;
  logic signed [5:0] cnt_nx;
  logic signed [5:0] diff;
  logic [9:0]        sym_v;
  logic [9:0]        sym_nx;

  // diff = N1q - N0q = 2*N1q - 8
  always_comb begin
    diff = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    sym_v = '0;
    cnt_v = cnt;
    unique case (1'b1)
      (cnt == 6'sd0) || (n1q == 4'd4): begin
        sym_v = {~qm[8], qm[8],
                 qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_v = qm[8] ? cnt + diff : cnt - diff;
      end
      ((cnt > 6'sd0) && (n1q > 4'd4)) ||
      ((cnt < 6'sd0) && (n1q < 4'd4)): begin
        sym_v = {1'b1, qm[8], ~qm[7:0]};
        cnt_v = cnt + (qm[8] ? 6'sd2 : 6'sd0) - diff;
      end
      default: begin
        sym_v = {1'b0, qm[8], qm[7:0]};
        cnt_v = cnt + diff - (qm[8] ? 6'sd0 : 6'sd2);
      end
    endcase
  end

  always_comb begin
    sym_nx = ctrl_code(ctrl_r);
    cnt_nx = '0;
    case (norm_mode(mode))
      MODE_VIDEO: begin
        sym_nx = sym_v;
        cnt_nx = cnt_v;
      end
      MODE_VGB:
        sym_nx = (CH_INDEX % 2 == 0) ? GB_EVEN : GB_ODD;
      MODE_TERC4:
        sym_nx = terc4(terc_r);
      MODE_DGB:
        sym_nx = (CH_INDEX == 0) ? terc4(terc_r) : GB_ODD;
      default:
        sym_nx = ctrl_code(ctrl_r);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmds <= CTRL_00;
      cnt  <= '0;
    end else begin
      tmds <= sym_nx;
      cnt  <= cnt_nx;
    end
  end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// Multi-channel HDMI TMDS encoder, fixed 2-cycle latency for all periods.
// Ports: clk, reset, mode, data/ctrl/terc per channel, tmds, out_mode.
module hdmi_tmds_encoder
  import hdmi_tmds_pkg::*;
#(
  parameter int         NUM_CH       = 3,
  parameter logic [9:0] GB_CH0_VIDEO = 10'b1011001100,
  parameter logic [9:0] GB_CH1_VIDEO = 10'b0100110011
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          mode,
  input  logic [8*NUM_CH-1:0] data,
  input  logic [2*NUM_CH-1:0] ctrl,
  input  logic [4*NUM_CH-1:0] terc,
  output logic [10*NUM_CH-1:0] tmds,
  output logic [2:0]          out_mode
);

  logic [2:0] mode_s1;
  logic [2:0] mode_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_s1 <= MODE_CTRL;
      mode_s2 <= MODE_CTRL;
    end else begin
      mode_s1 <= norm_mode(mode);
      mode_s2 <= mode_s1;
    end
  end

  assign out_mode = mode_s2;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    tmds_channel_enc #(
      .CH_INDEX (n),
      .GB_EVEN  (GB_CH0_VIDEO),
      .GB_ODD   (GB_CH1_VIDEO)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .mode  (mode_s1),
      .data  (data[8*n +: 8]),
      .ctrl  (ctrl[2*n +: 2]),
      .terc  (terc[4*n +: 4]),
      .tmds  (tmds[10*n +: 10])
    );
  end

endmodule
